mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the core data-memory bus, in parallel with DMEM. Decodes a 16-byte window at BASE_ADDR.

---
 rtl/mmio_uart_tx.sv | 215 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter that sits beside DMEM on the core data bus.
// Stored bytes queue in a small FIFO and are shifted out LSB first at DIV+1 clocks per bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    input  logic [3:0]  i_sel,
    output logic        o_hit,
    output logic [31:0] o_rdata,
    output logic        o_txd,
    output logic        o_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [7:0]      shift_r;
    logic [2:0]      bit_cnt_r;
    logic [15:0]     timer_r;
    logic            txd_r;
    logic            irq_r;
    logic            tx_en_r;
    logic            irq_en_r;
    logic [15:0]     div_r;
    logic            ovf_r;
    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic            hit_s;
    logic [1:0]      reg_sel_s;
    logic            wr_s;
    logic            push_s;
    logic            pop_s;
    logic            push_ok_s;
    logic            full_s;
    logic            empty_s;
    logic            ovf_set_s;
    logic            ovf_clr_s;
    logic            expire_s;
    logic [31:0]     rdata_s;
    logic            unused_s;

    assign hit_s     = (i_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel_s = i_addr[3:2];
    assign wr_s      = i_we & hit_s;
    assign full_s    = (count_r == CW'(FIFO_DEPTH));
    assign empty_s   = (count_r == CW'(0));
    assign push_s    = wr_s & (reg_sel_s == 2'd0) & i_sel[0];
    assign pop_s     = (state_r == ST_IDLE) & tx_en_r & ~empty_s;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign ovf_set_s = push_s & full_s & ~pop_s;
    assign ovf_clr_s = wr_s & (reg_sel_s == 2'd1) & i_sel[0] & i_wdata[3];
    assign expire_s  = (timer_r == 16'd0);
    assign unused_s  = ^{i_addr[1:0], i_wdata[31:16], i_sel[3:2]};

    // Register read mux; only the decoded window drives data.
    always_comb begin
        rdata_s = 32'd0;
        if (hit_s) begin
            case (reg_sel_s)
                2'd1: begin
                    rdata_s[0]    = (state_r != ST_IDLE);
                    rdata_s[1]    = full_s;
                    rdata_s[2]    = empty_s;
                    rdata_s[3]    = ovf_r;
                    rdata_s[12:8] = 5'(count_r);
                end
                2'd2: begin
                    rdata_s[0] = tx_en_r;
                    rdata_s[1] = irq_en_r;
                end
                2'd3:    rdata_s[15:0] = div_r;
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign o_hit   = hit_s;
    assign o_rdata = rdata_s;
    assign o_txd   = txd_r;
    assign o_irq   = irq_r;

    // CTRL and DIV byte-enabled register writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_en_r  <= 1'b0;
            irq_en_r <= 1'b0;
            div_r    <= DEFAULT_DIV;
        end else begin
            if (wr_s && (reg_sel_s == 2'd2) && i_sel[0]) begin
                tx_en_r  <= i_wdata[0];
                irq_en_r <= i_wdata[1];
            end
            if (wr_s && (reg_sel_s == 2'd3) && i_sel[0]) begin
                div_r[7:0] <= i_wdata[7:0];
            end
            if (wr_s && (reg_sel_s == 2'd3) && i_sel[1]) begin
                div_r[15:8] <= i_wdata[15:8];
            end
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= i_wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            ovf_r    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Transmit FSM with bit timer, shift register, serial line and interrupt.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'd0;
            bit_cnt_r <= 3'd0;
            timer_r   <= 16'd0;
            txd_r     <= 1'b1;
            irq_r     <= 1'b0;
        end else begin
            irq_r <= irq_en_r & empty_s & (state_r == ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r <= ST_START;
                        shift_r <= mem_r[rd_ptr_r];
                        txd_r   <= 1'b0;
                        timer_r <= div_r;
                    end
                end
                ST_START: begin
                    if (expire_s) begin
                        state_r   <= ST_DATA;
                        txd_r     <= shift_r[0];
                        shift_r   <= shift_r >> 1;
                        bit_cnt_r <= 3'd0;
                        timer_r   <= div_r;
                    end else begin
                        timer_r <= timer_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (expire_s) begin
                        timer_r <= div_r;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_STOP;
                            txd_r   <= 1'b1;
                        end else begin
                            txd_r     <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (expire_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    txd_r   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, FIFO overflow,
// address decode, interrupt timing and mid-frame reset / disable.
module tb_mmio_uart_tx;
    localparam logic [31:0] A_DATA = 32'h0000_FF00;
    localparam logic [31:0] A_STAT = 32'h0000_FF04;
    localparam logic [31:0] A_CTRL = 32'h0000_FF08;
    localparam logic [31:0] A_DIV  = 32'h0000_FF0C;

    logic        clk;
    logic        resetn;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_we;
    logic [3:0]  i_sel;
    logic        o_hit;
    logic [31:0] o_rdata;
    logic        o_txd;
    logic        o_irq;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx dut (
        .clk     (clk),
        .resetn  (resetn),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .i_we    (i_we),
        .i_sel   (i_sel),
        .o_hit   (o_hit),
        .o_rdata (o_rdata),
        .o_txd   (o_txd),
        .o_irq   (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        i_addr  = addr;
        i_wdata = data;
        i_sel   = sel;
        i_we    = 1'b1;
        @(posedge clk);
        #1;
        i_we    = 1'b0;
        i_sel   = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        i_addr = addr;
        #1;
        check(tag, o_rdata, exp);
    endtask

    // Entered just after the start-bit edge; leaves just after the edge that ends the stop bit.
    task automatic check_frame(input string tag, input logic [7:0] b, input int div);
        logic exp_bit;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) exp_bit = 1'b0;
            else if (k == 9) exp_bit = 1'b1;
            else exp_bit = b[k-1];
            check($sformatf("%s bit%0d entry", tag, k), {31'd0, o_txd}, {31'd0, exp_bit});
            tick(div);
            check($sformatf("%s bit%0d hold", tag, k), {31'd0, o_txd}, {31'd0, exp_bit});
            tick(1);
        end
    endtask

    initial begin
        resetn  = 1'b0;
        i_addr  = 32'd0;
        i_wdata = 32'd0;
        i_we    = 1'b0;
        i_sel   = 4'h0;

        // 1. reset state
        tick(2);
        check("rst txd", {31'd0, o_txd}, 32'd1);
        check("rst irq", {31'd0, o_irq}, 32'd0);
        resetn = 1'b1;
        rd("rst div", A_DIV, 32'd433);
        rd("rst status", A_STAT, 32'h0000_0004);
        rd("rst ctrl", A_CTRL, 32'd0);

        // 2. single 0xA5 frame at DIV=3
        wr(A_DIV, 32'd3, 4'b0011);
        wr(A_CTRL, 32'd1, 4'b0001);
        wr(A_DATA, 32'h0000_00A5, 4'b0001);
        tick(1);
        rd("t2 busy E1", A_STAT, 32'h0000_0005);
        check_frame("t2", 8'hA5, 3);
        rd("t2 idle E41", A_STAT, 32'h0000_0004);

        // 3. overflow with tx disabled, W1C, then 8 back-to-back frames
        wr(A_CTRL, 32'd0, 4'b0001);
        for (int i = 0; i < 9; i++) wr(A_DATA, 32'h10 + i, 4'b0001);
        rd("t3 full", A_STAT, 32'h0000_080A);
        wr(A_STAT, 32'h0000_0008, 4'b0001);
        rd("t3 w1c", A_STAT, 32'h0000_0802);
        wr(A_DIV, 32'd1, 4'b0011);
        wr(A_CTRL, 32'd1, 4'b0001);
        tick(1);
        for (int i = 0; i < 8; i++) begin
            check_frame($sformatf("t3 f%0d", i), 8'(8'h10 + i), 1);
            if (i < 7) tick(1);
        end
        rd("t3 drained", A_STAT, 32'h0000_0004);
        tick(4);
        check("t3 no 9th", {31'd0, o_txd}, 32'd1);

        // 4. decode misses and byte-enable qualification
        i_addr = A_DATA + 32'h40;
        #1;
        check("t4 hit", {31'd0, o_hit}, 32'd0);
        check("t4 rdata", o_rdata, 32'd0);
        i_addr = A_DIV;
        #1;
        check("t4 hit in", {31'd0, o_hit}, 32'd1);
        wr(A_DATA + 32'h40, 32'h77, 4'b1111);
        rd("t4 miss store", A_STAT, 32'h0000_0004);
        wr(A_DATA, 32'h77, 4'b0010);
        rd("t4 sel1 store", A_STAT, 32'h0000_0004);
        tick(2);
        check("t4 line idle", {31'd0, o_txd}, 32'd1);

        // 5. interrupt timing at DIV=0
        wr(A_DIV, 32'd0, 4'b0011);
        wr(A_CTRL, 32'd3, 4'b0001);
        tick(1);
        check("t5 irq idle", {31'd0, o_irq}, 32'd1);
        wr(A_DATA, 32'h3C, 4'b0001);
        check("t5 irq E0", {31'd0, o_irq}, 32'd1);
        tick(1);
        check("t5 irq fall", {31'd0, o_irq}, 32'd0);
        check_frame("t5", 8'h3C, 0);
        check("t5 irq at idle", {31'd0, o_irq}, 32'd0);
        tick(1);
        check("t5 irq rise", {31'd0, o_irq}, 32'd1);

        // 6a. reset during data bit 3
        wr(A_DIV, 32'd3, 4'b0011);
        wr(A_DATA, 32'h00, 4'b0001);
        tick(1);
        check("t6 start", {31'd0, o_txd}, 32'd0);
        tick(17);
        check("t6 bit3", {31'd0, o_txd}, 32'd0);
        resetn = 1'b0;
        tick(1);
        check("t6 rst txd", {31'd0, o_txd}, 32'd1);
        check("t6 rst irq", {31'd0, o_irq}, 32'd0);
        resetn = 1'b1;
        rd("t6 rst status", A_STAT, 32'h0000_0004);
        rd("t6 rst ctrl", A_CTRL, 32'd0);
        rd("t6 rst div", A_DIV, 32'd433);

        // 6b. clearing tx_en mid-frame completes the frame and keeps the queue
        wr(A_DIV, 32'd1, 4'b0011);
        wr(A_DATA, 32'h55, 4'b0001);
        wr(A_DATA, 32'hAA, 4'b0001);
        rd("t6 queued", A_STAT, 32'h0000_0200);
        wr(A_CTRL, 32'd1, 4'b0001);
        tick(1);
        check("t6 frame start", {31'd0, o_txd}, 32'd0);
        tick(4);
        wr(A_CTRL, 32'd0, 4'b0001);
        rd("t6 still busy", A_STAT, 32'h0000_0101);
        tick(30);
        rd("t6 kept", A_STAT, 32'h0000_0100);
        check("t6 line high", {31'd0, o_txd}, 32'd1);
        tick(10);
        check("t6 no next", {31'd0, o_txd}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
